ysyx_24080014_mem_arbiter: RTL and testbench



---
 rtl/ysyx_24080014_bus_pkg.sv | 19 +
 rtl/ysyx_24080014_arb_watchdog.sv | 29 ++
 rtl/ysyx_24080014_mem_arbiter.sv | 166 ++++++++++++++++
 tb/tb_ysyx_24080014_mem_arbiter.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_24080014_bus_pkg.sv
// Shared encodings for the core-side memory arbiter: FSM states, transaction
// owner, and default bus widths.
package ysyx_24080014_bus_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } arb_owner_e;

endpackage

// File: rtl/ysyx_24080014_arb_watchdog.sv
// Transaction watchdog for the memory arbiter; only instantiated when
// YSYX_24080014_ARB_TIMEOUT_EN is defined.
module ysyx_24080014_arb_watchdog #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic run,
  output logic expired
);

  localparam int RAW_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CNT_W = (RAW_W < 8) ? 8 : RAW_W;

  logic [CNT_W-1:0] count_reg;

  // The first REQ cycle sees count 0, so the limit is hit in cycle TIMEOUT_CYCLES.
  assign expired = run && (count_reg == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst || start) begin
      count_reg <= '0;
    end else if (run && !expired) begin
      count_reg <= count_reg + 1'b1;
    end
  end

endmodule

// File: rtl/ysyx_24080014_mem_arbiter.sv
// Two-master (IFU/LSU) to one-slave memory arbiter, one transaction in flight,
// LSU has fixed priority. Optional watchdog: YSYX_24080014_ARB_TIMEOUT_EN.
module ysyx_24080014_mem_arbiter
  import ysyx_24080014_bus_pkg::*;
#(
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int DATA_W         = DEF_DATA_W,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_W-1:0]   ifu_addr,
  output logic                ifu_resp_valid,
  output logic [DATA_W-1:0]   ifu_rdata,
  output logic                ifu_resp_err,
  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic                lsu_wen,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wmask,
  output logic                lsu_resp_valid,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic                lsu_resp_err,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic                mem_wen,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_resp_err
);

  localparam int MASK_W = DATA_W / 8;

  arb_state_e        state_reg, state_next;
  arb_owner_e        owner_reg, owner_next;
  logic              wen_reg, wen_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [DATA_W-1:0] wdata_reg, wdata_next;
  logic [MASK_W-1:0] wmask_reg, wmask_next;

  logic              ifu_grant, lsu_grant;
  logic              req_drive;
  logic              resp_fire;
  logic              resp_err;
  logic [DATA_W-1:0] resp_data;
  logic              timeout_hit;

`ifdef YSYX_24080014_ARB_TIMEOUT_EN
  ysyx_24080014_arb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .start   (ifu_grant || lsu_grant),
    .run     (state_reg != ST_IDLE),
    .expired (timeout_hit)
  );
`else
  logic timeout_unused;
  assign timeout_unused = (TIMEOUT_CYCLES != 0);
  assign timeout_hit    = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    owner_next = owner_reg;
    wen_next   = wen_reg;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
    wmask_next = wmask_reg;
    ifu_grant  = 1'b0;
    lsu_grant  = 1'b0;
    req_drive  = 1'b0;
    resp_fire  = 1'b0;
    resp_err   = 1'b0;
    resp_data  = '0;
    case (state_reg)
      ST_IDLE: begin
        lsu_grant = lsu_req_valid;
        ifu_grant = ifu_req_valid && !lsu_req_valid;
        if (lsu_grant) begin
          owner_next = OWN_LSU;
          wen_next   = lsu_wen;
          addr_next  = lsu_addr;
          wdata_next = lsu_wdata;
          wmask_next = lsu_wmask;
          state_next = ST_REQ;
        end else if (ifu_grant) begin
          owner_next = OWN_IFU;
          wen_next   = 1'b0;
          addr_next  = ifu_addr;
          wdata_next = '0;
          wmask_next = '0;
          state_next = ST_REQ;
        end
      end
      ST_REQ: begin
        req_drive = 1'b1;
        if (timeout_hit) begin
          resp_fire  = 1'b1;
          resp_err   = 1'b1;
          state_next = ST_IDLE;
        end else if (mem_req_ready) begin
          state_next = ST_RESP;
        end
      end
      ST_RESP: begin
        // A real response wins over a watchdog expiry landing in the same cycle.
        if (mem_resp_valid) begin
          resp_fire  = 1'b1;
          resp_err   = mem_resp_err;
          resp_data  = (owner_reg == OWN_LSU && wen_reg) ? '0 : mem_rdata;
          state_next = ST_IDLE;
        end else if (timeout_hit) begin
          resp_fire  = 1'b1;
          resp_err   = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      owner_reg <= OWN_IFU;
      wen_reg   <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      wmask_reg <= '0;
    end else begin
      state_reg <= state_next;
      owner_reg <= owner_next;
      wen_reg   <= wen_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
      wmask_reg <= wmask_next;
    end
  end

  // Every output is forced low while rst is high, even before the state clears.
  assign ifu_req_ready = ifu_grant && !rst;
  assign lsu_req_ready = lsu_grant && !rst;

  assign mem_req_valid = req_drive && !rst;
  assign mem_wen       = mem_req_valid && wen_reg;
  assign mem_addr      = mem_req_valid ? addr_reg  : '0;
  assign mem_wdata     = mem_req_valid ? wdata_reg : '0;
  assign mem_wmask     = mem_req_valid ? wmask_reg : '0;

  assign ifu_resp_valid = resp_fire && (owner_reg == OWN_IFU) && !rst;
  assign ifu_rdata      = ifu_resp_valid ? resp_data : '0;
  assign ifu_resp_err   = ifu_resp_valid && resp_err;

  assign lsu_resp_valid = resp_fire && (owner_reg == OWN_LSU) && !rst;
  assign lsu_rdata      = lsu_resp_valid ? resp_data : '0;
  assign lsu_resp_err   = lsu_resp_valid && resp_err;

endmodule

// File: tb/tb_ysyx_24080014_mem_arbiter.sv
// Self-checking bench for the memory arbiter: vector table plus hand sequences,
// responses checked through a scoreboard queue.
module tb_ysyx_24080014_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_err;
  logic [31:0] ifu_addr, ifu_rdata;
  logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid, lsu_resp_err;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic [3:0]  lsu_wmask;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid, mem_resp_err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;

  int compared   = 0;
  int mismatched = 0;
  int cycle_cnt  = 0;

  typedef struct {
    logic        ifu_v;
    logic [31:0] ifu_a;
    logic        lsu_v;
    logic        wen;
    logic [31:0] lsu_a;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    int          delay;
    logic [31:0] mrdata;
    logic        merr;
    logic        exp_lsu;
    logic [31:0] exp_addr;
    logic        exp_wen;
    logic [3:0]  exp_wmask;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic        lsu;
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } sb_t;

  sb_t  sb_q[$];
  vec_t vecs[6];

  ysyx_24080014_mem_arbiter #(
    .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata), .ifu_resp_err(ifu_resp_err),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_wen(lsu_wen),
    .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata), .lsu_resp_err(lsu_resp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_wen(mem_wen),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata), .mem_resp_err(mem_resp_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s actual=%b required=%b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Response monitor: every pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    sb_t e;
    if (ifu_resp_valid || lsu_resp_valid) begin
      if (sb_q.size() == 0) begin
        check("unexpected_resp", {30'd0, ifu_resp_valid, lsu_resp_valid}, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check1("resp_owner_lsu", lsu_resp_valid, e.lsu);
        check1("resp_owner_ifu", ifu_resp_valid, !e.lsu);
        check("resp_rdata", e.lsu ? lsu_rdata : ifu_rdata, e.rdata);
        check1("resp_err", e.lsu ? lsu_resp_err : ifu_resp_err, e.err);
        check("resp_cycle", cycle_cnt, e.cyc);
        $display("txn resp owner=%s rdata=%h err=%b cycle=%0d",
                 lsu_resp_valid ? "LSU" : "IFU", lsu_resp_valid ? lsu_rdata : ifu_rdata,
                 lsu_resp_valid ? lsu_resp_err : ifu_resp_err, cycle_cnt);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Memory side of one transaction, entered in the first REQ cycle.
  task automatic mem_side(input int delay, input logic [31:0] ea, input logic ew,
                          input logic [3:0] em, input logic chk_wd, input logic [31:0] ewd,
                          input logic [31:0] rd, input logic re);
    for (int i = 0; i < delay; i++) begin
      mem_req_ready = 1'b0;
      ifu_req_valid = 1'b1;
      lsu_req_valid = 1'b1;
      #1;
      check1("stall_req_valid", mem_req_valid, 1'b1);
      check("stall_addr", mem_addr, ea);
      check("stall_no_ready", {30'd0, ifu_req_ready, lsu_req_ready}, 32'd0);
      step();
    end
    if (delay > 0) begin
      ifu_req_valid = 1'b0;
      lsu_req_valid = 1'b0;
    end
    mem_req_ready = 1'b1;
    #1;
    check1("req_valid", mem_req_valid, 1'b1);
    check("req_addr", mem_addr, ea);
    check1("req_wen", mem_wen, ew);
    check("req_wmask", {28'd0, mem_wmask}, {28'd0, em});
    if (chk_wd) check("req_wdata", mem_wdata, ewd);
    check("req_no_ready", {30'd0, ifu_req_ready, lsu_req_ready}, 32'd0);
    step();
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b1;
    mem_rdata      = rd;
    mem_resp_err   = re;
    #1;
    check1("resp_state_req_low", mem_req_valid, 1'b0);
    check("resp_no_ready", {30'd0, ifu_req_ready, lsu_req_ready}, 32'd0);
    step();
    mem_resp_valid = 1'b0;
    mem_rdata      = '0;
    mem_resp_err   = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    sb_t e;
    ifu_req_valid = v.ifu_v;
    ifu_addr      = v.ifu_a;
    lsu_req_valid = v.lsu_v;
    lsu_wen       = v.wen;
    lsu_addr      = v.lsu_a;
    lsu_wdata     = v.wdata;
    lsu_wmask     = v.wmask;
    #1;
    check1("lsu_req_ready", lsu_req_ready, v.exp_lsu);
    check1("ifu_req_ready", ifu_req_ready, !v.exp_lsu);
    e = '{v.exp_lsu, v.exp_rdata, v.exp_err, cycle_cnt + 2 + v.delay};
    sb_q.push_back(e);
    step();
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
    mem_side(v.delay, v.exp_addr, v.exp_wen, v.exp_wmask, v.exp_lsu, v.wdata, v.mrdata, v.merr);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench timed out");
  end

  initial begin
    sb_t e;
    //          ifu_v ifu_a         lsu_v wen lsu_a         wdata         wm    dly mrdata        merr  exp_lsu addr          wen   wm    rdata         err
    vecs[0] = '{1'b1, 32'h80000000, 1'b0, 1'b0, 32'h0,      32'h0,        4'h0, 0, 32'h00000413, 1'b0, 1'b0, 32'h80000000, 1'b0, 4'h0, 32'h00000413, 1'b0};
    vecs[1] = '{1'b0, 32'h0,        1'b1, 1'b0, 32'h80000100, 32'h0,      4'hF, 0, 32'h12345678, 1'b0, 1'b1, 32'h80000100, 1'b0, 4'hF, 32'h12345678, 1'b0};
    vecs[2] = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h80001000, 32'hDEADBEEF, 4'hF, 0, 32'hAAAA5555, 1'b0, 1'b1, 32'h80001000, 1'b1, 4'hF, 32'h00000000, 1'b0};
    vecs[3] = '{1'b1, 32'h80000004, 1'b1, 1'b0, 32'h80000200, 32'h0,      4'hF, 2, 32'hCAFEF00D, 1'b1, 1'b1, 32'h80000200, 1'b0, 4'hF, 32'hCAFEF00D, 1'b1};
    vecs[4] = '{1'b1, 32'h80000008, 1'b0, 1'b0, 32'h0,      32'h0,        4'h0, 5, 32'h00100093, 1'b1, 1'b0, 32'h80000008, 1'b0, 4'h0, 32'h00100093, 1'b1};
    vecs[5] = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h80000300, 32'h01234567, 4'h3, 1, 32'hFFFFFFFF, 1'b1, 1'b1, 32'h80000300, 1'b1, 4'h3, 32'h00000000, 1'b1};

    // Reset with requests and a response pending: everything must stay low.
    rst = 1'b1;
    ifu_req_valid = 1'b1; ifu_addr = 32'h80000000;
    lsu_req_valid = 1'b1; lsu_wen = 1'b1; lsu_addr = 32'h1234; lsu_wdata = 32'h5678; lsu_wmask = 4'hF;
    mem_req_ready = 1'b1; mem_resp_valid = 1'b1; mem_rdata = 32'hFFFFFFFF; mem_resp_err = 1'b1;
    repeat (3) step();
    check("reset_ctrl", {24'd0, ifu_req_ready, lsu_req_ready, mem_req_valid, ifu_resp_valid,
                         lsu_resp_valid, ifu_resp_err, lsu_resp_err, mem_wen}, 32'd0);
    check("reset_data", ifu_rdata | lsu_rdata | mem_addr | mem_wdata | {28'd0, mem_wmask}, 32'd0);
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0; lsu_wen = 1'b0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = '0; mem_resp_err = 1'b0;
    rst = 1'b0;
    step();

    for (int i = 0; i < 6; i++) begin
      $display("txn vector %0d issued", i);
      run_vec(vecs[i]);
    end

    // LSU store and IFU fetch together; IFU stays valid and must win right after.
    $display("txn both-valid sequence");
    ifu_req_valid = 1'b1; ifu_addr = 32'h80000010;
    lsu_req_valid = 1'b1; lsu_wen = 1'b1; lsu_addr = 32'h80001000;
    lsu_wdata = 32'hDEADBEEF; lsu_wmask = 4'hF;
    #1;
    check1("both_lsu_ready", lsu_req_ready, 1'b1);
    check1("both_ifu_ready", ifu_req_ready, 1'b0);
    e = '{1'b1, 32'h0, 1'b0, cycle_cnt + 2};
    sb_q.push_back(e);
    step();
    lsu_req_valid = 1'b0;
    mem_side(0, 32'h80001000, 1'b1, 4'hF, 1'b1, 32'hDEADBEEF, 32'h11111111, 1'b0);
    #1;
    check1("ifu_after_lsu_ready", ifu_req_ready, 1'b1);
    e = '{1'b0, 32'h00000013, 1'b0, cycle_cnt + 2};
    sb_q.push_back(e);
    step();
    ifu_req_valid = 1'b0;
    mem_side(0, 32'h80000010, 1'b0, 4'h0, 1'b0, 32'h0, 32'h00000013, 1'b0);

    // Reset while in RESP: transaction is dropped with no response.
    $display("txn reset-in-resp sequence");
    ifu_req_valid = 1'b1; ifu_addr = 32'h80000020;
    step();
    ifu_req_valid = 1'b0; mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0; rst = 1'b1; mem_resp_valid = 1'b1; mem_rdata = 32'h0BADF00D;
    #1;
    check("rst_resp_no_pulse", {30'd0, ifu_resp_valid, lsu_resp_valid}, 32'd0);
    step();
    rst = 1'b0; mem_resp_valid = 1'b0;
    #1;
    check("rst_after_ctrl", {27'd0, ifu_req_ready, lsu_req_ready, mem_req_valid,
                             ifu_resp_valid, lsu_resp_valid}, 32'd0);
    check("rst_after_data", ifu_rdata | lsu_rdata | mem_addr, 32'd0);
    step();
    mem_resp_valid = 1'b1; mem_rdata = 32'h0BADF00D;
    #1;
    check("late_resp_no_pulse", {30'd0, ifu_resp_valid, lsu_resp_valid}, 32'd0);
    check1("late_resp_no_req", mem_req_valid, 1'b0);
    step();
    mem_resp_valid = 1'b0; mem_rdata = '0;
    run_vec(vecs[1]);

    // Spurious responses while idle.
    $display("txn spurious-idle-resp sequence");
    mem_resp_valid = 1'b1; mem_rdata = 32'h55AA55AA; mem_resp_err = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      check("idle_spurious", {30'd0, ifu_resp_valid, lsu_resp_valid}, 32'd0);
      step();
    end
    mem_resp_valid = 1'b0; mem_rdata = '0; mem_resp_err = 1'b0;
    run_vec(vecs[0]);

`ifdef YSYX_24080014_ARB_TIMEOUT_EN
    // Memory accepts an LSU load but never answers: forced error after 16 cycles.
    $display("txn timeout sequence");
    lsu_req_valid = 1'b1; lsu_wen = 1'b0; lsu_addr = 32'h80000400; lsu_wmask = 4'hF;
    #1;
    check1("to_lsu_ready", lsu_req_ready, 1'b1);
    e = '{1'b1, 32'h0, 1'b1, cycle_cnt + 16};
    sb_q.push_back(e);
    step();
    lsu_req_valid = 1'b0; mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    repeat (20) step();
    mem_resp_valid = 1'b1; mem_rdata = 32'h77777777;
    #1;
    check("to_late_resp", {30'd0, ifu_resp_valid, lsu_resp_valid}, 32'd0);
    step();
    mem_resp_valid = 1'b0; mem_rdata = '0;
    run_vec(vecs[0]);
`endif

    repeat (2) step();
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
